// File: rtl/zx81_tape_pkg.sv
// Shared types and timing for the ZX81 tape path (encoder and receiver).
// All cycle counts assume the 500kHz tape clock.
package zx81_tape_pkg;

  typedef enum logic [1:0] {IDLE, HI, LO, GAP} rx_state_e;

  // Nominal encoder timing: 150us pulses split high/low, 1300us bit gap.
  localparam int PULSE_HI_CYC = 75;
  localparam int PULSE_LO_CYC = 75;
  localparam int BIT_GAP_CYC  = 650;
  localparam int ZERO_PULSES  = 4;
  localparam int ONE_PULSES   = 9;

  // Receiver acceptance windows.
  localparam int RX_FILT       = 3;
  localparam int RX_PULSE_MIN  = 25;
  localparam int RX_PULSE_MAX  = 200;
  localparam int RX_GAP_MIN    = 400;
  localparam int RX_ONE_MIN    = 7;
  localparam int RX_TIMEOUT    = 5000;
  localparam int BIT_PULSE_MIN = 2;
  localparam int BIT_PULSE_MAX = 12;

  localparam logic [7:0] NAME_END_MASK = 8'h80;

  function automatic logic is_name_end(input logic [7:0] b);
    return (b & NAME_END_MASK) != 8'h00;
  endfunction

endpackage

// File: rtl/zx81_tape_rx_filter.sv
// EAR input conditioning: 2-FF synchroniser followed by a FILT-sample debounce.
// rise/fall are registered and coincide with the cycle t takes its new level.
module tape_in_filter
  import zx81_tape_pkg::*;
#(
  parameter int FILT = RX_FILT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tape_in,
  output logic t,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILT + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          t_q, t_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    t_d    = t_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_q[1] != t_q) begin
      if (cnt_q == CW'(FILT - 1)) begin
        t_d    = sync_q[1];
        rise_d = sync_q[1];
        fall_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      t_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], tape_in};
      cnt_q  <= cnt_d;
      t_q    <= t_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign t    = t_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/zx81_tape_rx.sv
// ZX81 cassette receiver: counts pulses per bit, assembles bytes MSB first,
// tags filename bytes and reports framing errors and block timeouts.
module zx81_tape_rx
  import zx81_tape_pkg::*;
#(
  parameter int FILT      = RX_FILT,
  parameter int PULSE_MIN = RX_PULSE_MIN,
  parameter int PULSE_MAX = RX_PULSE_MAX,
  parameter int GAP_MIN   = RX_GAP_MIN,
  parameter int ONE_MIN   = RX_ONE_MIN,
  parameter int TIMEOUT   = RX_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tape_in,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        is_name,
  output logic [15:0] byte_cnt,
  output logic        bit_err,
  output logic        block_end,
  output logic        busy
);

  localparam logic [9:0]  PMIN_C   = 10'(PULSE_MIN);
  localparam logic [9:0]  PMAX_C   = 10'(PULSE_MAX);
  localparam logic [12:0] GAP_C    = 13'(GAP_MIN);
  localparam logic [12:0] TO_C     = 13'(TIMEOUT);
  localparam logic [3:0]  ONE_C    = 4'(ONE_MIN);
  localparam logic [3:0]  BPMIN_C  = 4'(BIT_PULSE_MIN);
  localparam logic [3:0]  BPMAX_C  = 4'(BIT_PULSE_MAX);

  logic t, rise, fall;

  tape_in_filter #(.FILT(FILT)) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .tape_in(tape_in),
    .t      (t),
    .rise   (rise),
    .fall   (fall)
  );

  rx_state_e   state_q, state_d;
  logic [9:0]  hi_cnt_q, hi_cnt_d;
  logic [12:0] lo_cnt_q, lo_cnt_d;
  logic [3:0]  pulse_cnt_q, pulse_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        in_name_q, in_name_d;
  logic        got_byte_q, got_byte_d;
  logic        block_done_q, block_done_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        is_name_q, is_name_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        bit_err_q, bit_err_d;
  logic        block_end_q, block_end_d;
  logic        busy_q, busy_d;

  logic        bit_end, fail;
  logic [9:0]  hi_inc;
  logic [12:0] lo_inc;
  logic [7:0]  new_shreg;

  assign hi_inc    = (hi_cnt_q == 10'h3FF) ? hi_cnt_q : hi_cnt_q + 10'd1;
  assign lo_inc    = (lo_cnt_q >= TO_C) ? TO_C : lo_cnt_q + 13'd1;
  assign new_shreg = {shreg_q[6:0], (pulse_cnt_q >= ONE_C)};

  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    in_name_d    = in_name_q;
    got_byte_d   = got_byte_q;
    block_done_d = block_done_q;
    byte_data_d  = byte_data_q;
    is_name_d    = is_name_q;
    byte_cnt_d   = byte_cnt_q;
    busy_d       = busy_q;
    byte_valid_d = 1'b0;
    bit_err_d    = 1'b0;
    block_end_d  = 1'b0;
    bit_end      = 1'b0;
    fail         = 1'b0;

    if (!enable) begin
      state_d     = IDLE;
      shreg_d     = '0;
      bit_cnt_d   = '0;
      pulse_cnt_d = '0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rise) begin
          state_d     = HI;
          hi_cnt_d    = 10'd1;
          pulse_cnt_d = '0;
          busy_d      = 1'b1;
          // A timed-out block leaves its count readable until the next one starts.
          if (block_done_q) begin
            byte_cnt_d   = '0;
            in_name_d    = 1'b1;
            got_byte_d   = 1'b0;
            block_done_d = 1'b0;
          end else if (!got_byte_q) begin
            in_name_d = 1'b1;
          end
        end
        HI: if (fall) begin
          if (hi_cnt_q < PMIN_C) begin
            fail = 1'b1;
          end else begin
            state_d     = LO;
            pulse_cnt_d = (pulse_cnt_q == 4'hF) ? pulse_cnt_q : pulse_cnt_q + 4'd1;
            lo_cnt_d    = 13'd1;
          end
        end else if (hi_cnt_q >= PMAX_C) begin
          fail = 1'b1;
        end else begin
          hi_cnt_d = hi_inc;
        end
        // The level is low on entry to LO and GAP, so t high means a rising edge.
        LO: if (t) begin
          state_d  = HI;
          hi_cnt_d = 10'd1;
        end else begin
          lo_cnt_d = lo_inc;
          if (lo_inc == GAP_C) begin
            state_d = GAP;
            bit_end = 1'b1;
          end
        end
        GAP: if (t) begin
          state_d     = HI;
          hi_cnt_d    = 10'd1;
          pulse_cnt_d = '0;
        end else begin
          lo_cnt_d = lo_inc;
          if (lo_inc == TO_C) begin
            state_d      = IDLE;
            block_end_d  = 1'b1;
            bit_err_d    = (bit_cnt_q != 3'd0);
            busy_d       = 1'b0;
            shreg_d      = '0;
            bit_cnt_d    = '0;
            block_done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (bit_end) begin
        if (pulse_cnt_q < BPMIN_C || pulse_cnt_q > BPMAX_C) begin
          fail = 1'b1;
        end else begin
          shreg_d     = new_shreg;
          bit_cnt_d   = bit_cnt_q + 3'd1;
          pulse_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            byte_data_d  = new_shreg;
            byte_valid_d = 1'b1;
            is_name_d    = in_name_q;
            got_byte_d   = 1'b1;
            if (in_name_q) begin
              if (is_name_end(new_shreg)) in_name_d = 1'b0;
            end else if (byte_cnt_q != 16'hFFFF) begin
              byte_cnt_d = byte_cnt_q + 16'd1;
            end
          end
        end
      end

      if (fail) begin
        state_d     = IDLE;
        bit_err_d   = 1'b1;
        shreg_d     = '0;
        bit_cnt_d   = '0;
        pulse_cnt_d = '0;
        busy_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      pulse_cnt_q  <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      in_name_q    <= 1'b1;
      got_byte_q   <= 1'b0;
      block_done_q <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      is_name_q    <= 1'b0;
      byte_cnt_q   <= '0;
      bit_err_q    <= 1'b0;
      block_end_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      in_name_q    <= in_name_d;
      got_byte_q   <= got_byte_d;
      block_done_q <= block_done_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      is_name_q    <= is_name_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_err_q    <= bit_err_d;
      block_end_q  <= block_end_d;
      busy_q       <= busy_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign is_name    = is_name_q;
  assign byte_cnt   = byte_cnt_q;
  assign bit_err    = bit_err_q;
  assign block_end  = block_end_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_zx81_tape_rx.sv
// Scoreboard bench for zx81_tape_rx: stimulus pushes expected bytes, a monitor
// pops and compares them on each byte_valid strobe.
`timescale 1ns/1ns
module tb_zx81_tape_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tape_in = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        is_name;
  logic [15:0] byte_cnt;
  logic        bit_err;
  logic        block_end;
  logic        busy;

  always #1000 clk = ~clk;

  zx81_tape_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .tape_in   (tape_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .is_name   (is_name),
    .byte_cnt  (byte_cnt),
    .bit_err   (bit_err),
    .block_end (block_end),
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   err_seen = 0;
  int   end_seen = 0;
  int   both_seen = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every byte strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_byte: got %0h, expected no strobe", byte_data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("byte_data", int'(byte_data), int'(e.data));
          checkOutput("is_name", int'(is_name), int'(e.name));
        end
      end
      if (bit_err) err_seen++;
      if (block_end) end_seen++;
      if (bit_err && block_end) both_seen++;
    end
  end

  task automatic hold(input logic lvl, input int n);
    tape_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int pulses, input int hi, input int lo, input int gap);
    for (int p = 0; p < pulses; p++) begin
      hold(1'b1, hi);
      hold(1'b0, (p == pulses - 1) ? lo + gap : lo);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
    checkOutput("sb_drain", sb_q.size(), 0);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic name,
                               input int hi, input int lo, input int gap);
    exp_t e;
    e.data = b;
    e.name = name;
    sb_q.push_back(e);
    for (int i = 7; i >= 0; i--) send_bit(b[i] ? 9 : 4, hi, lo, gap);
    drain();
  endtask

  task automatic wait_block_end(input int target);
    for (int i = 0; i < 6000 && end_seen < target; i++) @(negedge clk);
    checkOutput("block_end_wait", end_seen, target);
  endtask

  initial begin
    logic [7:0] a5;
    exp_t       e;

    repeat (3) @(negedge clk);
    checkOutput("rst_byte_data", int'(byte_data), 0);
    checkOutput("rst_byte_valid", int'(byte_valid), 0);
    checkOutput("rst_byte_cnt", int'(byte_cnt), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_bit_err", int'(bit_err), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);

    // Encoder-timed block: name byte with end flag, two data bytes, then silence.
    applyStimulus(8'hBF, 1'b1, 75, 75, 650);
    applyStimulus(8'h00, 1'b0, 75, 75, 650);
    applyStimulus(8'hFF, 1'b0, 75, 75, 650);
    wait_block_end(1);
    checkOutput("t1_bit_err", err_seen, 0);
    checkOutput("t1_byte_cnt", int'(byte_cnt), 2);
    checkOutput("t1_busy", int'(busy), 0);

    // New block: two name bytes, an aborted partial byte, then a data byte.
    applyStimulus(8'h26, 1'b1, 28, 28, 380);
    applyStimulus(8'hA7, 1'b1, 28, 28, 380);
    send_bit(4, 28, 28, 380);
    send_bit(9, 28, 28, 380);
    send_bit(4, 28, 28, 380);
    enable = 1'b0;
    hold(1'b0, 10);
    checkOutput("en_off_busy", int'(busy), 0);
    enable = 1'b1;
    hold(1'b0, 10);
    applyStimulus(8'h55, 1'b0, 28, 28, 380);
    checkOutput("t2_byte_cnt", int'(byte_cnt), 1);
    checkOutput("t2_bit_err", err_seen, 0);

    // Short high pulse is a framing error.
    hold(1'b1, 20);
    hold(1'b0, 600);
    checkOutput("short_pulse_err", err_seen, 1);
    checkOutput("short_pulse_busy", int'(busy), 0);

    // Off-nominal pulse widths and gaps still decode.
    a5 = 8'hA5;
    e.data = a5;
    e.name = 1'b0;
    sb_q.push_back(e);
    for (int i = 7; i >= 0; i--)
      send_bit(a5[i] ? 9 : 4, (i % 2) ? 90 : 60, 30, (i % 2) ? 770 : 420);
    drain();
    checkOutput("a5_byte_cnt", int'(byte_cnt), 2);

    // Pulse counts outside 2..12 are rejected.
    send_bit(1, 28, 28, 380);
    hold(1'b0, 50);
    checkOutput("one_pulse_err", err_seen, 2);
    send_bit(14, 28, 28, 380);
    hold(1'b0, 50);
    checkOutput("many_pulse_err", err_seen, 3);

    // Partial byte at timeout: block_end and bit_err together.
    for (int i = 0; i < 5; i++) send_bit(4, 28, 28, 380);
    wait_block_end(2);
    checkOutput("partial_both", both_seen, 1);
    checkOutput("partial_err", err_seen, 4);
    checkOutput("partial_byte_cnt", int'(byte_cnt), 2);

    // Asynchronous reset mid-byte clears outputs immediately.
    hold(1'b1, 28);
    hold(1'b0, 28);
    hold(1'b1, 28);
    checkOutput("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_byte_data", int'(byte_data), 0);
    checkOutput("mid_rst_is_name", int'(is_name), 0);
    checkOutput("mid_rst_byte_cnt", int'(byte_cnt), 0);
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
